// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) for the single memory port of the multi-cycle RV32 core.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_ack,
    output logic [DATA_W-1:0]     o_if_rdata,
    input  logic                  i_dm_req,
    input  logic                  i_dm_we,
    input  logic [ADDR_W-1:0]     i_dm_addr,
    input  logic [DATA_W-1:0]     i_dm_wdata,
    input  logic [DATA_W/8-1:0]   i_dm_be,
    output logic                  o_dm_ack,
    output logic [DATA_W-1:0]     o_dm_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_be,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_busy
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    typedef struct packed {
        logic              owner_dm;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    logic [1:0]        state;
    req_t              cur;
    req_t              win;
    logic              grant_dm;
    logic              any_req;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    assign any_req = i_if_req | i_dm_req;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // last_dm=0 means fetch was granted last, so data wins the first contest after reset
    logic last_dm;

    always_comb begin
        grant_dm = i_dm_req & (~i_if_req | ~last_dm);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)
            last_dm <= 1'b0;
        else if (state == S_IDLE && any_req)
            last_dm <= grant_dm;
    end
`else
    always_comb begin
        grant_dm = i_dm_req;
    end
`endif

    // Fetches are always full-word reads
    always_comb begin
        win.owner_dm = grant_dm;
        win.we       = grant_dm ? i_dm_we    : 1'b0;
        win.addr     = grant_dm ? i_dm_addr  : i_if_addr;
        win.wdata    = grant_dm ? i_dm_wdata : '0;
        win.be       = grant_dm ? i_dm_be    : '1;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= S_IDLE;
            cur        <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        cur   <= win;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        if (cur.owner_dm)
                            dm_rdata_q <= i_mem_rdata;
                        else
                            if_rdata_q <= i_mem_rdata;
                        state <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory outputs are zero outside REQ so the port looks idle during reset and waits
    always_comb begin
        o_mem_req   = (state == S_REQ);
        o_mem_we    = o_mem_req & cur.we;
        o_mem_addr  = o_mem_req ? cur.addr  : '0;
        o_mem_wdata = o_mem_req ? cur.wdata : '0;
        o_mem_be    = o_mem_req ? cur.be    : '0;
        o_if_ack    = (state == S_RESP) & ~cur.owner_dm;
        o_dm_ack    = (state == S_RESP) &  cur.owner_dm;
        o_if_rdata  = if_rdata_q;
        o_dm_rdata  = dm_rdata_q;
        o_busy      = (state != S_IDLE);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory port of the multi-cycle RV32 core between two requesters: the instruction-fetch path and the load/store data path.
- Sits between the core's control/datapath and the memory. Accepts one request at a time, forwards it to memory and waits for completion.
- Returns the read data and a one-cycle acknowledge to the requester that owns the transaction.
- Handles multi-cycle (wait-state) memory so the main FSM can stall on acks.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous reset, active-low
- i_if_req  in  1  fetch request; held high until o_if_ack
- i_if_addr  in  ADDR_W  fetch address
- o_if_ack  out  1  one-cycle fetch completion pulse
- o_if_rdata  out  DATA_W  fetched word; valid while o_if_ack=1
- i_dm_req  in  1  data request; held high until o_dm_ack
- i_dm_we  in  1  1 = store, 0 = load
- i_dm_addr  in  ADDR_W  data address
- i_dm_wdata  in  DATA_W  store data
- i_dm_be  in  DATA_W/8  store byte enables
- o_dm_ack  out  1  one-cycle data completion pulse
- o_dm_rdata  out  DATA_W  load data; valid while o_dm_ack=1
- o_mem_req  out  1  memory request
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_be  out  DATA_W/8  memory byte enables
- i_mem_ready  in  1  memory accepts the request this cycle
- i_mem_rvalid  in  1  memory completion (reads and writes)
- i_mem_rdata  in  DATA_W  memory read data, valid with i_mem_rvalid
- o_busy  out  1  arbiter state != IDLE

Behaviour:

States: IDLE, REQ, WAIT, RESP, held in a registered FSM.

IDLE:
- Samples i_if_req and i_dm_req.
- If either is high: selects a winner, registers the owner plus the winner's addr/we/wdata/be, and goes to REQ.
- A fetch winner forces we=0 and be=all-ones.

Arbitration (default):
- Fixed priority, data over fetch, because a pending data access belongs to an instruction already in flight.

REQ:
- o_mem_req=1 and memory outputs are driven from the registered copies.
- Outputs are held stable until i_mem_ready=1; then go to WAIT.

WAIT:
- o_mem_req=0.
- On i_mem_rvalid=1: register i_mem_rdata and go to RESP.
- i_mem_ready and i_mem_rvalid both high in REQ is illegal (response before acceptance). The rvalid is ignored.

RESP:
- Owner's ack=1 for exactly one cycle and its rdata = registered data. Go to IDLE.
- The non-owner's ack stays 0. Its rdata is don't-care; the implementation holds the last value.

Requester rules:
- A requester holds req, addr and data stable from assertion until its ack.
- A req still high in the cycle after its ack is treated as a new request.

Latency: minimum 4 cycles, request to ack.
- Cycle 0: req.
- Cycle 1: mem_req with ready=1.
- Cycle 2: rvalid.
- Cycle 3: ack.
- Each memory wait state adds one cycle.

Other rules:
- Only one transaction is ever outstanding.
- A request arriving while busy waits, unacknowledged, until the next IDLE.
- i_mem_rvalid in IDLE or REQ is ignored.
- Simultaneous if/dm requests in IDLE: only the winner proceeds. The loser is granted in the first IDLE after the winner's RESP, unless starved per the arbitration policy.

Reset (asynchronous, any state):
- FSM goes to IDLE.
- All outputs are 0: acks, o_mem_req, o_mem_we, addr/wdata/be, rdata, o_busy.
- Any in-flight memory transaction is abandoned; its late rvalid is ignored.
- The round-robin pointer resets to "fetch last granted", so data wins first.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register is updated on entry to REQ. When both requesters are high in IDLE, the one not granted last wins.
- Undefined: fixed data-over-fetch priority. No last-grant register exists, and fetch can starve while i_dm_req is asserted back-to-back.

Test Plan:
1. Fetch only, addr=0x0000_0010, ready=1, rvalid one cycle later with rdata=0x0051_0093 -> o_mem_req at cycle 1 with we=0, be=4'hF; o_if_ack=1 with rdata=0x0051_0093 at cycle 3; o_dm_ack stays 0.
2. Store addr=0x100, wdata=0xDEAD_BEEF, be=4'b0011, ready delayed 3 cycles -> o_mem_* held stable over 4 REQ cycles; o_dm_ack one cycle after rvalid; total 7 cycles.
3. Simultaneous if+dm in IDLE (default build) -> dm served first, if served next; the two acks are 4 cycles apart with zero memory wait.
4. Same stimulus, MEM_ARBITER_ROUND_ROBIN_EN, both reqs held continuously for 4 transactions -> grant order dm, if, dm, if.
5. arstn low during WAIT, then late rvalid after release -> all outputs 0 during reset; rvalid ignored; no ack; o_busy=0.
6. Stray i_mem_rvalid in IDLE with no requests -> no ack; state stays IDLE.
